piso_shift_param: RTL and testbench
===================================

# piso_shift_param

Parametrised parallel-in/serial-out shift register: next generation of the 4-bit PISO in the shift-register set. Captures a WIDTH-bit word on an accepted load, then emits it one bit per clock on `q`, MSB-first or LSB-first as selected per word. A ready/valid handshake allows gap-free back-to-back words. An optional even-parity bit is appended after each word. Feeds serial links and serial-consumer blocks in the same design.

## Interface
- `WIDTH`, 8, data word width in bits; legal range 1..32.
- `CNT_W`, `$clog2(WIDTH+1)`, bit-counter width; derived, never overridden.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `load`  in  1  load request; accepted only when `ready`=1 at the rising edge.
- `din`  in  WIDTH  parallel word; sampled only on an accepted load.
- `lsb_first`  in  1  bit order for the word being loaded: 0 = MSB first, 1 = LSB first; sampled with `din`.
- `ready`  out  1  block can accept a load this cycle.
- `q`  out  1  serial data bit; 0 whenever `q_valid`=0.
- `q_valid`  out  1  `q` carries a live bit this cycle.
- `done`  out  1  one-cycle pulse, high during the final serial bit of a frame.

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with the parity feature).
- IDLE: `ready`=1, `q`=0, `q_valid`=0, `done`=0.
- Accepted load (`load`=1 and `ready`=1 at the edge): register `din` into the shift register, latch `lsb_first`, compute the parity of `din`, set bit counter to WIDTH-1, go to SHIFT.
- SHIFT: `q` = shift-register MSB (MSB mode) or LSB (LSB mode), `q_valid`=1. Each edge shifts one position in the latched direction, zero-fill, and decrements the counter.
- Last data bit (counter = 0):
  - Without parity: `done`=1, `ready`=1. Next state is SHIFT if a load is accepted, else IDLE.
  - With parity: next state is PAR.
- PAR: `q` = parity bit, `q_valid`=1, `done`=1, `ready`=1. Next state is SHIFT if a load is accepted, else IDLE.
- `ready` is combinational from state and counter. It is 1 in IDLE and in the final-bit cycle of a frame, and 0 otherwise.
- A load while `ready`=0 is ignored. `din` and `lsb_first` changes during a frame have no effect.
- WIDTH=1: SHIFT lasts one cycle, and that cycle is the final data bit.

## Timing
- Reset values: state IDLE, shift register 0, counter 0, `q`=0, `q_valid`=0, `done`=0, `ready`=1. Reset takes effect asynchronously, mid-frame included, and the frame is discarded.
- Latency: the first bit appears on `q` in the cycle after the accepting edge (one clock).
- Frame length: WIDTH cycles of `q_valid`, or WIDTH+1 with parity.
- Back-to-back: a load accepted during the final-bit cycle makes the new frame's first bit follow with no idle cycle, so `q_valid` stays continuously high.
- Deassertion of `reset` is synchronous-safe: the first accepted load is the first rising edge with `reset`=1 and `load`=1.
- Outputs are registered state decodes. No combinational path exists from `load`, `din` or `lsb_first` to `q`, `q_valid` or `done`. `ready` depends on state only.

## Configuration
- Macro `PISO_PARITY_EN`.
- When defined: the PAR state exists. An even-parity bit (XOR of all `din` bits as captured) follows every word, frame length is WIDTH+1, and `done`/`ready` move to the PAR cycle.
- When undefined: no PAR state and no parity logic. Frame length is WIDTH, and `done`/`ready` assert on the last data bit.

## Test plan
- WIDTH=4, no parity, `din`=4'b1101, `lsb_first`=0, load for one cycle -> `q` = 1,1,0,1 on the next 4 cycles, `q_valid`=1 for exactly 4 cycles, `done` high on the 4th, then IDLE with `q`=0.
- Same word with `lsb_first`=1 -> `q` = 1,0,1,1.
- Back-to-back: load 4'b1010 (MSB-first), then load 4'b0110 during its `done` cycle -> 8 contiguous valid bits 1,0,1,0,0,1,1,0 and two `done` pulses.
- Load 4'b1111 during the 2nd bit of a 4'b0001 frame -> ignored; output stays 0,0,0,1, then IDLE.
- Assert `reset`=0 mid-frame at bit 2 -> `q`, `q_valid`, `done` go to 0 immediately and `ready`=1. After release, load 4'b0011 -> clean frame 0,0,1,1.
- With `PISO_PARITY_EN`, sweep `din`=0..15 in both orders -> 5 bits per frame, 5th bit = XOR of `din`, `done` on the 5th bit. For 4'b1101 the frame is 1,1,0,1,1.

Source files
------------

// File: rtl/piso_shift_param.sv
// piso_shift_param
//   Parametrised parallel-in/serial-out shift register with a ready/valid
//   style load handshake. A WIDTH-bit word is captured on an accepted load
//   and emitted one bit per clock on q, MSB-first or LSB-first as selected
//   per word. A load accepted during the final cycle of a frame starts the
//   next frame with no idle gap.
//
//   Optional feature (macro PISO_PARITY_EN): an even-parity bit (XOR of the
//   captured word) is appended after every word in a PAR state. done/ready
//   then move to the PAR cycle.
//
// Parameters
//   WIDTH  data word width, 1..32
//   CNT_W  bit-counter width, derived from WIDTH
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   load       in   load request, accepted when ready=1 at the edge
//   din        in   parallel word, sampled on an accepted load
//   lsb_first  in   bit order of the loaded word (0 MSB first, 1 LSB first)
//   ready      out  a load is accepted at the next edge
//   q          out  serial data bit, 0 when q_valid=0
//   q_valid    out  q carries a live bit
//   done       out  high during the final serial bit of a frame
module piso_shift_param #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             lsb_first,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             done
);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        SHIFT
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q,    sr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               lsb_q,   lsb_d;
`ifdef PISO_PARITY_EN
    logic               par_q,   par_d;
`endif

    logic               last_bit;
    logic               accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            lsb_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            lsb_q   <= lsb_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic. ready depends on registered state only, so accept
    // has no path to the serial outputs other than through the flops.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        lsb_d    = lsb_q;
`ifdef PISO_PARITY_EN
        par_d    = par_q;
`endif
        last_bit = (state_q == SHIFT) && (cnt_q == '0);

`ifdef PISO_PARITY_EN
        ready    = (state_q == IDLE) || (state_q == PAR);
`else
        ready    = (state_q == IDLE) || last_bit;
`endif
        accept   = load && ready;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                // Zero-fill shift in the latched direction.
                if (lsb_q) begin
                    sr_d = sr_q >> 1;
                end else begin
                    sr_d = sr_q << 1;
                end
                if (last_bit) begin
`ifdef PISO_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accepted load overrides the end-of-frame transition, which
        // gives gap-free back-to-back frames.
        if (accept) begin
            state_d = SHIFT;
            sr_d    = din;
            lsb_d   = lsb_first;
            cnt_d   = CNT_W'(WIDTH - 1);
`ifdef PISO_PARITY_EN
            par_d   = ^din;
`endif
        end
    end

    // Output decode from registered state only.
    always_comb begin
        q       = 1'b0;
        q_valid = 1'b0;
        done    = 1'b0;
        case (state_q)
            SHIFT: begin
                q       = lsb_q ? sr_q[0] : sr_q[WIDTH-1];
                q_valid = 1'b1;
`ifndef PISO_PARITY_EN
                done    = last_bit;
`endif
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                q       = par_q;
                q_valid = 1'b1;
                done    = 1'b1;
            end
`endif
            default: begin
                q       = 1'b0;
                q_valid = 1'b0;
                done    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_shift_param.sv
// tb_piso_shift_param
//   Directed bench for piso_shift_param at WIDTH=4. Table of single frames
//   plus hand sequences for back-to-back, ignored load and mid-frame reset.
//   Follows PISO_PARITY_EN when defined (parity sweep over all 16 words).
module tb_piso_shift_param;

    localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
    localparam int unsigned FL = W + 1;
`else
    localparam int unsigned FL = W;
`endif

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] din;
    logic         lsb_first;
    logic         ready;
    logic         q;
    logic         q_valid;
    logic         done;

    int n_cmp;
    int n_bad;

    piso_shift_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .din       (din),
        .lsb_first (lsb_first),
        .ready     (ready),
        .q         (q),
        .q_valid   (q_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        logic         lsb;
        logic [W-1:0] seq;   // data bits in emission order, seq[W-1] first
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic expect_cycle(input string nm, input logic eq, input logic ev,
                                input logic ed, input logic er);
        chk({nm, " q"},       q,       eq);
        chk({nm, " q_valid"}, q_valid, ev);
        chk({nm, " done"},    done,    ed);
        chk({nm, " ready"},   ready,   er);
    endtask

    function automatic logic exp_bit(input logic [W-1:0] seq, input logic [W-1:0] d,
                                     input int unsigned i);
        if (i < W) return seq[W-1-i];
        return ^d;
    endfunction

    function automatic logic [W-1:0] rev(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int unsigned k = 0; k < W; k++) r[k] = d[W-1-k];
        return r;
    endfunction

    // Entered and left at a negedge.
    task automatic run_frame(input logic [W-1:0] d, input logic lsb,
                             input logic [W-1:0] seq, input string nm);
        load      = 1'b1;
        din       = d;
        lsb_first = lsb;
        @(posedge clk);
        @(negedge clk);
        load      = 1'b0;
        din       = ~d;      // must not disturb the frame in flight
        lsb_first = ~lsb;
        for (int unsigned i = 0; i < FL; i++) begin
            expect_cycle($sformatf("%s bit%0d", nm, i), exp_bit(seq, d, i), 1'b1,
                         i == FL - 1, i == FL - 1);
            @(negedge clk);
        end
        expect_cycle({nm, " idle"}, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{din: 4'b1101, lsb: 1'b0, seq: 4'b1101};
        vecs[1] = '{din: 4'b1101, lsb: 1'b1, seq: 4'b1011};
        vecs[2] = '{din: 4'b1010, lsb: 1'b0, seq: 4'b1010};
        vecs[3] = '{din: 4'b0110, lsb: 1'b1, seq: 4'b0110};
        vecs[4] = '{din: 4'b0001, lsb: 1'b0, seq: 4'b0001};
        vecs[5] = '{din: 4'b0001, lsb: 1'b1, seq: 4'b1000};
        vecs[6] = '{din: 4'b1000, lsb: 1'b1, seq: 4'b0001};
        vecs[7] = '{din: 4'b0000, lsb: 1'b0, seq: 4'b0000};
        vecs[8] = '{din: 4'b1111, lsb: 1'b1, seq: 4'b1111};
        vecs[9] = '{din: 4'b0011, lsb: 1'b0, seq: 4'b0011};

        reset     = 1'b0;
        load      = 1'b0;
        din       = '0;
        lsb_first = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        expect_cycle("post_reset idle", 1'b0, 1'b0, 1'b0, 1'b1);

        for (int v = 0; v < 10; v++) begin
            run_frame(vecs[v].din, vecs[v].lsb, vecs[v].seq, $sformatf("vec%0d", v));
        end

        // Back-to-back: second word accepted in the final cycle of the first.
        load      = 1'b1;
        din       = 4'b1010;
        lsb_first = 1'b0;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        for (int unsigned i = 0; i < FL; i++) begin
            expect_cycle($sformatf("b2b A bit%0d", i), exp_bit(4'b1010, 4'b1010, i),
                         1'b1, i == FL - 1, i == FL - 1);
            if (i == FL - 1) begin
                load      = 1'b1;
                din       = 4'b0110;
                lsb_first = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        din  = '0;
        for (int unsigned i = 0; i < FL; i++) begin
            expect_cycle($sformatf("b2b B bit%0d", i), exp_bit(4'b0110, 4'b0110, i),
                         1'b1, i == FL - 1, i == FL - 1);
            @(negedge clk);
        end
        expect_cycle("b2b idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Load during the 2nd bit while ready=0 is ignored.
        load      = 1'b1;
        din       = 4'b0001;
        lsb_first = 1'b0;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        for (int unsigned i = 0; i < FL; i++) begin
            expect_cycle($sformatf("ign bit%0d", i), exp_bit(4'b0001, 4'b0001, i),
                         1'b1, i == FL - 1, i == FL - 1);
            if (i == 1) begin
                load      = 1'b1;
                din       = 4'b1111;
                lsb_first = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        expect_cycle("ign idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a frame.
        load      = 1'b1;
        din       = 4'b1111;
        lsb_first = 1'b0;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        expect_cycle("rst_mid bit0", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        expect_cycle("rst_mid bit1", 1'b1, 1'b1, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1 expect_cycle("rst_mid async", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        expect_cycle("rst_mid held", 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        expect_cycle("rst_mid released", 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(4'b0011, 1'b0, 4'b0011, "after_rst");

`ifdef PISO_PARITY_EN
        for (int d = 0; d < 16; d++) begin
            run_frame(W'(d), 1'b0, W'(d), $sformatf("par msb %0d", d));
            run_frame(W'(d), 1'b1, rev(W'(d)), $sformatf("par lsb %0d", d));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
